// File: rtl/shift_pkg.sv
// Shared shift-unit constants: mode codes (also used by decode) and FSM state encoding.
package shift_pkg;

   localparam logic [1:0] MODE_SRL = 2'b00;
   localparam logic [1:0] MODE_ROL = 2'b01;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   function automatic logic mode_valid(input logic [1:0] mode);
      return (mode == MODE_SRL) || (mode == MODE_ROL);
   endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational SRL/ROL step of 1 bit, or 4 bits when big is set.
// Zero latency; reserved modes pass the data through untouched.
module shift_step
   import shift_pkg::*;
(
   input  logic [15:0] data,
   input  logic [1:0]  mode,
   input  logic        big,
   output logic [15:0] result
);

   always_comb begin
      result = data;
      case (mode)
         MODE_SRL: result = big ? {4'b0000, data[15:4]} : {1'b0, data[15:1]};
         MODE_ROL: result = big ? {data[11:0], data[15:12]} : {data[14:0], data[15]};
         default:  result = data;
      endcase
   end

endmodule

// File: rtl/rev_seq_shifter.sv
// Multi-cycle SRL/ROL coprocessor; done pulses N+1 cycles after the accepting edge.
// start is ignored while busy; REV_SHIFTER_FAST_STEP_EN enables 4-bit steps when cnt_r >= 4.
module rev_seq_shifter
   import shift_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] Shift_In,
   input  logic [3:0]  Shift_Val,
   input  logic [1:0]  Mode,
   output logic [15:0] Shift_Out,
   output logic        busy,
   output logic        done
);

   state_t      state_r;
   logic [15:0] data_r;
   logic [3:0]  cnt_r;
   logic [1:0]  mode_r;
   logic        big_step;
   logic [15:0] step_data;
   logic [3:0]  cnt_next;
   logic        in_mode_ok;

`ifdef REV_SHIFTER_FAST_STEP_EN
   assign big_step = (cnt_r >= 4'd4);
`else
   assign big_step = 1'b0;
`endif

   assign cnt_next   = big_step ? (cnt_r - 4'd4) : (cnt_r - 4'd1);
   assign in_mode_ok = mode_valid(Mode);

   shift_step u_step (
      .data   (data_r),
      .mode   (mode_r),
      .big    (big_step),
      .result (step_data)
   );

   // Shift_Out and done are loaded on the edge that enters DONE so both are
   // valid together during the DONE cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         data_r    <= 16'h0000;
         cnt_r     <= 4'd0;
         mode_r    <= MODE_SRL;
         Shift_Out <= 16'h0000;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  cnt_r  <= Shift_Val;
                  mode_r <= Mode;
                  data_r <= in_mode_ok ? Shift_In : 16'h0000;
                  busy   <= 1'b1;
                  if (in_mode_ok && (Shift_Val != 4'd0)) begin
                     state_r <= SHIFT;
                  end else begin
                     state_r   <= DONE;
                     done      <= 1'b1;
                     Shift_Out <= in_mode_ok ? Shift_In : 16'h0000;
                  end
               end
            end
            SHIFT: begin
               data_r <= step_data;
               cnt_r  <= cnt_next;
               if (cnt_next == 4'd0) begin
                  state_r   <= DONE;
                  done      <= 1'b1;
                  Shift_Out <= step_data;
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/rev_seq_shifter.md
# rev_seq_shifter

Multi-cycle shift unit providing the complementary directions to the processor's combinational shifter: Shift Right Logical and Rotate Left on a 16-bit operand. It sits beside the ALU as a start/done coprocessor. The datapath issues an operation, stalls on `busy`, and captures `Shift_Out` when `done` pulses. Each cycle shifts by one bit, or by four with the fast-step option.

## Interface
- No parameters; width fixed at 16, count width fixed at 4.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `Shift_In`  in  16  operand.
- `Shift_Val`  in  4  shift amount, 0–15.
- `Mode`  in  2  00 = SRL, 01 = ROL, 10/11 = reserved.
- `Shift_Out`  out  16  registered result; holds the last result until the next DONE.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; `Shift_Out` is valid in the same cycle.

## Operation
- States are IDLE, SHIFT and DONE. All outputs decode from registers, so there are no combinational paths from inputs to outputs.
- **IDLE** with `start` = 1 at a clock edge:
  - Latch `Shift_In` into `data_r`, `Shift_Val` into `cnt_r` and `Mode` into `mode_r`.
  - Next state is SHIFT if `Shift_Val` != 0 and Mode is valid, otherwise DONE.
- **IDLE, reserved Mode:** `data_r` loads 16'h0000.
- **IDLE, `Shift_Val` = 0:** `data_r` loads `Shift_In` unchanged.
- **SHIFT**, each edge:
  - SRL: `data_r` <= {1'b0, data_r[15:1]}.
  - ROL: `data_r` <= {data_r[14:0], data_r[15]}.
  - `cnt_r` decrements by the step size. When the post-step count reaches 0, next state is DONE.
- **DONE:** `Shift_Out` <= `data_r` on entry, `done` = 1 for exactly one cycle, then IDLE.
- **`start` while `busy`:** ignored and not queued. Inputs may change freely after the accepting edge.
- **Back-to-back:** `start` asserted during the `done` cycle is not accepted. It is accepted on the following IDLE cycle.
- **Reset:** `rst_n` low at any edge, including mid-SHIFT, forces:
  - state = IDLE, `data_r` = 0, `cnt_r` = 0, `Shift_Out` = 16'h0000, `busy` = 0, `done` = 0.
  - No `done` is produced for the aborted operation.

## Timing
- Cycle 0 is the edge that accepts `start`.
- Without fast step:
  - N ≥ 1: `busy` rises after edge 0, `done` is high during cycle N+1, and `busy` falls after edge N+1.
  - N = 0 or reserved Mode: `done` in cycle 1.
- Total occupancy is N+1 cycles; 16 cycles worst case (N = 15).
- Throughput is one operation per N+2 cycles, counting the mandatory IDLE cycle.

## Configuration
- Macro: `REV_SHIFTER_FAST_STEP_EN`.
- **Defined:** in SHIFT, if `cnt_r` ≥ 4, shift by 4 and subtract 4; otherwise shift by 1.
  - Latency becomes floor(N/4) + (N mod 4) + 1 cycles to `done`; N = 15 gives `done` in cycle 7.
  - Results are identical to the undefined case.
- **Undefined:** 1-bit step only; no 4-bit mux is synthesized.

## Structure
- Shared package `shift_pkg` holds:
  - Mode constants `MODE_SRL` = 2'b00 and `MODE_ROL` = 2'b01.
  - State encoding IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10.
  - These mode constants are shared with the decode stage.
- One sub-module, `shift_step`: combinational step (in 16, mode 2, big 1 → out 16).
  - It performs a 1-bit or 4-bit SRL/ROL.
  - It is instantiated once. Its `big` input is tied to 0 when the macro is undefined.
- The top level contains the FSM, counter and output register.

## Test plan
- SRL 0x8001 by 1 → `done` in cycle 2, `Shift_Out` = 0x4000, `busy` high for cycles 1–2.
- ROL 0x8001 by 4 → `Shift_Out` = 0x0018. `done` in cycle 5, or cycle 2 with the macro defined.
- SRL 0xF000 by 15 → 0x0001. `done` in cycle 16, or cycle 7 with the macro defined. ROL 0x1234 by 15 → 0x091A.
- `Shift_Val` = 0, In = 0xBEEF → `done` in cycle 1, `Shift_Out` = 0xBEEF. Mode = 10 with In = 0xFFFF → `Shift_Out` = 0x0000.
- `start` pulsed again in cycle 3 of a 15-bit SRL → ignored. A single `done` occurs, and the second operation starts only when `start` is reasserted in IDLE.
- `rst_n` low in cycle 4 of an 8-bit ROL → next cycle shows IDLE, `Shift_Out` = 0, `busy` = 0, and no `done`. The next operation after reset completes correctly.
